// File: rtl/ccg_pkg.sv
// Shared types and defaults for the ccg_lut_eval truth-table evaluator.
package ccg_pkg;

  typedef enum logic [1:0] {
    ST_CFG   = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } ccg_state_e;

  localparam int CCG_NUM_IN  = 5;
  localparam int CCG_NUM_OUT = 12;

  // Row-index width; a single-function build still needs a 1-bit index port.
  function automatic int ccg_idx_w(input int num_out);
    return (num_out > 1) ? $clog2(num_out) : 1;
  endfunction

endpackage

// File: rtl/ccg_lut_bank.sv
// Truth-table storage: one row of 2**NUM_IN bits per output function.
// Single write port, combinational read of every function at one input vector.
module ccg_lut_bank
  import ccg_pkg::*;
#(
  parameter int NUM_IN  = CCG_NUM_IN,
  parameter int NUM_OUT = CCG_NUM_OUT
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            wr_en,
  input  logic [ccg_idx_w(NUM_OUT)-1:0]   wr_idx,
  input  logic [2**NUM_IN-1:0]            wr_data,
  input  logic [NUM_IN-1:0]               rd_addr,
  output logic [NUM_OUT-1:0]              rd_f
);

  localparam int IDX_W = ccg_idx_w(NUM_OUT);

  logic [2**NUM_IN-1:0] rows [NUM_OUT];

  // Row write; indices that match no row (>= NUM_OUT) simply land nowhere.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int j = 0; j < NUM_OUT; j++) rows[j] <= '0;
    end else if (wr_en) begin
      for (int j = 0; j < NUM_OUT; j++) begin
        if (wr_idx == IDX_W'(j)) rows[j] <= wr_data;
      end
    end
  end

  // Read bit rd_addr of every row to form the function vector.
  always_comb begin
    rd_f = '0;
    for (int j = 0; j < NUM_OUT; j++) rd_f[j] = rows[j][rd_addr];
  end

endmodule

// File: rtl/ccg_lut_eval.sv
// Configurable multi-output boolean evaluator with a two-stage pipeline.
// Optional feature: define CCG_LUT_EVAL_PARITY_EN to add out_par, the XOR of
// out_f, registered alongside it.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_CFG   | table writable, no inputs accepted, cfg_ready high
//   ST_RUN   | table frozen, vectors accepted and evaluated
//   ST_DRAIN | no new inputs, in-flight results delivered, then ST_CFG
module ccg_lut_eval
  import ccg_pkg::*;
#(
  parameter int NUM_IN  = CCG_NUM_IN,
  parameter int NUM_OUT = CCG_NUM_OUT
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            cfg_we,
  input  logic [ccg_idx_w(NUM_OUT)-1:0]   cfg_idx,
  input  logic [2**NUM_IN-1:0]            cfg_data,
  input  logic                            cfg_commit,
  input  logic                            cfg_unlock,
  output logic                            cfg_ready,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_IN-1:0]               in_x,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_OUT-1:0]              out_f
`ifdef CCG_LUT_EVAL_PARITY_EN
  ,
  output logic                            out_par
`endif
);

  ccg_state_e          state;
  logic                s1_v;
  logic [NUM_IN-1:0]   s1_x;
  logic                s2_v;
  logic [NUM_OUT-1:0]  s2_f;
  logic [NUM_OUT-1:0]  lut_f;
  logic                accept;
  logic                s2_load;

  assign cfg_ready = (state == ST_CFG);
  assign in_ready  = (state == ST_RUN) & (!s1_v | !s2_v | out_ready);
  assign accept    = in_valid & in_ready;
  // S1 moves forward whenever S2 is empty or its result is being taken.
  assign s2_load   = s1_v & (!s2_v | out_ready);
  assign out_valid = s2_v;
  assign out_f     = s2_f;

  ccg_lut_bank #(
    .NUM_IN  (NUM_IN),
    .NUM_OUT (NUM_OUT)
  ) u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (cfg_we & (state == ST_CFG)),
    .wr_idx  (cfg_idx),
    .wr_data (cfg_data),
    .rd_addr (s1_x),
    .rd_f    (lut_f)
  );

  // Mode sequencing; requests outside their own state are ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_CFG;
    end else begin
      case (state)
        ST_CFG:   if (cfg_commit) state <= ST_RUN;
        ST_RUN:   if (cfg_unlock) state <= ST_DRAIN;
        ST_DRAIN: if (!s1_v && !s2_v) state <= ST_CFG;
        default:  state <= ST_CFG;
      endcase
    end
  end

  // Two-stage pipe: S1 holds the input vector, S2 holds the looked-up result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v <= 1'b0;
      s1_x <= '0;
      s2_v <= 1'b0;
      s2_f <= '0;
    end else begin
      if (accept) begin
        s1_v <= 1'b1;
        s1_x <= in_x;
      end else if (s2_load) begin
        s1_v <= 1'b0;
      end
      if (s2_load) begin
        s2_v <= 1'b1;
        s2_f <= lut_f;
      end else if (out_ready) begin
        s2_v <= 1'b0;
      end
    end
  end

`ifdef CCG_LUT_EVAL_PARITY_EN
  // Parity of the result, captured on the same edge as out_f.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_par <= 1'b0;
    end else if (s2_load) begin
      out_par <= ^lut_f;
    end
  end
`endif

endmodule

// File: tb/tb_ccg_lut_eval.sv
// Directed bench for ccg_lut_eval: stimulus pushes expected results into a
// queue, a monitor pops and compares on every out_valid & out_ready.
module tb_ccg_lut_eval;

  logic          clk;
  logic          rst_n;
  logic          cfg_we;
  logic [3:0]    cfg_idx;
  logic [31:0]   cfg_data;
  logic          cfg_commit;
  logic          cfg_unlock;
  logic          cfg_ready;
  logic          in_valid;
  logic          in_ready;
  logic [4:0]    in_x;
  logic          out_valid;
  logic          out_ready;
  logic [11:0]   out_f;
`ifdef CCG_LUT_EVAL_PARITY_EN
  logic          out_par;
`endif

  int            n_vec = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            last_acc = 0;
  logic [11:0]   exp_q [$];
  int            xfer_cyc [$];
  logic [31:0]   mdl [12];

  ccg_lut_eval #(.NUM_IN(5), .NUM_OUT(12)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we),
    .cfg_idx    (cfg_idx),
    .cfg_data   (cfg_data),
    .cfg_commit (cfg_commit),
    .cfg_unlock (cfg_unlock),
    .cfg_ready  (cfg_ready),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_f      (out_f)
`ifdef CCG_LUT_EVAL_PARITY_EN
    ,
    .out_par    (out_par)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] model_f(input logic [4:0] x);
    logic [11:0] f;
    f = '0;
    for (int j = 0; j < 12; j++) f[j] = mdl[j][x];
    return f;
  endfunction

  // upd: the bench expects this write to land (device is in CFG).
  task automatic cfg_write(input int idx, input logic [31:0] data, input bit upd);
    cfg_we   = 1'b1;
    cfg_idx  = 4'(idx);
    cfg_data = data;
    if (upd && idx < 12) mdl[idx] = data;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic send(input logic [4:0] x, input logic [11:0] e);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    in_valid = 1'b1;
    in_x = x;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        last_acc = cyc;
        done = 1'b1;
      end else if (++n > 200) begin
        chk("send_timeout", in_ready, 1);
        done = 1'b1;
      end
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain_wait;
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
    tick();
  endtask

  task automatic unlock_and_wait;
    int n;
    n = 0;
    cfg_unlock = 1'b1;
    tick();
    cfg_unlock = 1'b0;
    @(negedge clk);
    chk("drain_in_ready", in_ready, 0);
    while (!cfg_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_to_cfg", cfg_ready, 1);
    chk("drain_all_out", exp_q.size(), 0);
    tick();
  endtask

  task automatic commit;
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  // Scoreboard monitor.
  initial begin
    logic [11:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        xfer_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("unexpected_result", out_valid, 0);
        end else begin
          e = exp_q.pop_front();
          chk("out_f", out_f, e);
`ifdef CCG_LUT_EVAL_PARITY_EN
          chk("out_par", out_par, ^e);
`endif
        end
      end
    end
  end

  initial begin
    logic [31:0] tbl [12];
    logic [11:0] held;
    int first_acc;

    tbl = '{32'hAAAA_AAAA, 32'hCCCC_CCCC, 32'hF0F0_F0F0, 32'hFF00_FF00,
            32'hFFFF_0000, 32'h8000_0000, 32'h55AA_55AA, 32'hFFFF_FFFE,
            32'h0000_0001, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF};
    for (int j = 0; j < 12; j++) mdl[j] = '0;

    rst_n = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_data = '0;
    cfg_commit = 1'b0; cfg_unlock = 1'b0; in_valid = 1'b0; in_x = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_f", out_f, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Unlock while in CFG has no effect.
    cfg_unlock = 1'b1;
    tick();
    cfg_unlock = 1'b0;
    @(negedge clk);
    chk("unlock_in_cfg", cfg_ready, 1);
    tick();

    // Row 6 = x0^x3, written in the same cycle as the commit.
    cfg_we = 1'b1; cfg_idx = 4'd6; cfg_data = 32'h55AA_55AA; cfg_commit = 1'b1;
    mdl[6] = 32'h55AA_55AA;
    tick();
    cfg_we = 1'b0; cfg_commit = 1'b0;
    @(negedge clk);
    chk("run_cfg_ready", cfg_ready, 0);
    chk("run_in_ready", in_ready, 1);
    tick();
    send(5'b01001, 12'h000);
    send(5'b00001, 12'h040);
    drain_wait();

    // Commit while running is ignored.
    commit();
    @(negedge clk);
    chk("commit_in_run", in_ready, 1);
    tick();

    // Writes during RUN must not touch the table.
    cfg_write(6, 32'hFFFF_FFFF, 1'b0);
    send(5'b01001, 12'h000);
    send(5'b00001, 12'h040);
    send(5'b11000, 12'h040);
    drain_wait();

    // Unlock with two results in flight.
    send(5'b01000, 12'h040);
    send(5'b00000, 12'h000);
    unlock_and_wait();

    // Full table; out-of-range indices are dropped.
    for (int j = 0; j < 12; j++) cfg_write(j, tbl[j], 1'b1);
    for (int j = 12; j < 16; j++) cfg_write(j, 32'hFFFF_FFFF, 1'b1);
    commit();

    // Back-to-back stream with timing check.
    xfer_cyc.delete();
    first_acc = 0;
    for (int x = 0; x < 32; x++) begin
      send(5'(x), model_f(5'(x)));
      if (x == 0) first_acc = last_acc;
    end
    drain_wait();
    chk("stream_count", xfer_cyc.size(), 32);
    for (int k = 0; k < 32 && k < xfer_cyc.size(); k++)
      chk("stream_timing", xfer_cyc[k], first_acc + 2 + k);

    // Backpressure mid-stream.
    fork
      begin
        for (int x = 0; x < 12; x++) send(5'(31 - x), model_f(5'(31 - x)));
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        held = out_f;
        chk("bp_valid", out_valid, 1);
        chk("bp_in_ready", in_ready, 0);
        repeat (4) begin
          @(negedge clk);
          chk("bp_hold_f", out_f, held);
          chk("bp_hold_valid", out_valid, 1);
          chk("bp_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain_wait();

    // Reset with results in flight.
    out_ready = 1'b0;
    send(5'd5, model_f(5'd5));
    send(5'd6, model_f(5'd6));
    @(negedge clk);
    chk("pre_rst_valid", out_valid, 1);
    rst_n = 1'b0;
    exp_q.delete();
    for (int j = 0; j < 12; j++) mdl[j] = '0;
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_cfg_ready", cfg_ready, 1);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_out_f", out_f, 0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    commit();
    send(5'd31, 12'h000);
    send(5'd9, 12'h000);
    drain_wait();

`ifdef CCG_LUT_EVAL_PARITY_EN
    unlock_and_wait();
    for (int j = 0; j < 12; j++) cfg_write(j, 32'hFFFF_FFFF, 1'b1);
    commit();
    send(5'd0, 12'hFFF);
    drain_wait();
    unlock_and_wait();
    cfg_write(11, 32'h0000_0000, 1'b1);
    commit();
    send(5'd0, 12'h7FF);
    drain_wait();
`endif

    chk("final_sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
